// File: rtl/alu_exec_if.sv
// Execute-stage bus: request, operands and the write-back result.
interface alu_exec_if #(parameter int WORD_SIZE = 16);
  logic                 start;
  logic [3:0]           opcode;
  logic [1:0]           dest;
  logic [WORD_SIZE-1:0] op_a;
  logic [WORD_SIZE-1:0] op_b;
  logic                 busy;
  logic                 done;
  logic                 wb_write;
  logic [1:0]           wb_addr;
  logic [WORD_SIZE-1:0] wb_data;
  logic [3:0]           flags;
  logic                 illegal;

  modport master (
    output start, opcode, dest, op_a, op_b,
    input  busy, done, wb_write, wb_addr, wb_data, flags, illegal
  );

  modport slave (
    input  start, opcode, dest, op_a, op_b,
    output busy, done, wb_write, wb_addr, wb_data, flags, illegal
  );
endinterface

// File: rtl/alu_exec.sv
// Execute stage: single-cycle ALU ops plus an optional 16-iteration shift-add
// multiplier, enabled by defining ALU_EXEC_MUL_EN.
module alu_exec #(
  parameter int WORD_SIZE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  alu_exec_if.slave  bus
);

  localparam int W = WORD_SIZE;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_ORR = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_TCP = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_LHI = 4'd8;
`ifdef ALU_EXEC_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd9;
`endif

`ifdef ALU_EXEC_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  typedef struct packed {
    logic         illegal;
    logic [3:0]   flags;
    logic [W-1:0] data;
  } alu_res_t;

  // Flags are {N,Z,C,V}; N and Z always follow the result word.
  function automatic alu_res_t alu_single(input logic [3:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    alu_res_t     r;
    logic [W:0]   ext;
    logic         c;
    logic         v;
    r   = '0;
    ext = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      OP_ADD: begin
        ext    = {1'b0, a} + {1'b0, b};
        r.data = ext[W-1:0];
        c      = ext[W];
        v      = (a[W-1] == b[W-1]) && (r.data[W-1] != a[W-1]);
      end
      OP_SUB: begin
        ext    = {1'b0, a} - {1'b0, b};
        r.data = ext[W-1:0];
        c      = ~ext[W];
        v      = (a[W-1] != b[W-1]) && (r.data[W-1] != a[W-1]);
      end
      OP_AND: r.data = a & b;
      OP_ORR: r.data = a | b;
      OP_NOT: r.data = ~a;
      OP_TCP: r.data = '0 - a;
      OP_SHL: r.data = {a[W-2:0], 1'b0};
      OP_SHR: r.data = {a[W-1], a[W-1:1]};
      OP_LHI: r.data = {b[7:0], 8'h00};
      default: r.illegal = 1'b1;
    endcase
    r.flags = {r.data[W-1], (r.data == '0), c, v};
    return r;
  endfunction

  state_t       state_q, state_d;
  logic         done_q, done_d;
  logic         wb_write_q, wb_write_d;
  logic [1:0]   wb_addr_q, wb_addr_d;
  logic [W-1:0] wb_data_q, wb_data_d;
  logic [3:0]   flags_q, flags_d;
  logic         illegal_q, illegal_d;
  alu_res_t     res;

`ifdef ALU_EXEC_MUL_EN
  logic [W-1:0]   mcand_q, mcand_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [1:0]     dest_q, dest_d;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] prod_next;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      done_q     <= 1'b0;
      wb_write_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      flags_q    <= '0;
      illegal_q  <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      mcand_q    <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      dest_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      wb_write_q <= wb_write_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      flags_q    <= flags_d;
      illegal_q  <= illegal_d;
`ifdef ALU_EXEC_MUL_EN
      mcand_q    <= mcand_d;
      prod_q     <= prod_d;
      cnt_q      <= cnt_d;
      dest_q     <= dest_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    wb_write_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    flags_d    = flags_q;
    illegal_d  = illegal_q;
    res        = alu_single(bus.opcode, bus.op_a, bus.op_b);
`ifdef ALU_EXEC_MUL_EN
    mcand_d    = mcand_q;
    prod_d     = prod_q;
    cnt_d      = cnt_q;
    dest_d     = dest_q;
    // One shift-add step: add multiplicand into the high half when the
    // multiplier LSB is set, then shift the whole product right.
    mul_sum    = {1'b0, prod_q[2*W-1:W]} + {1'b0, (prod_q[0] ? mcand_q : {W{1'b0}})};
    prod_next  = {mul_sum, prod_q[W-1:1]};
`endif

    case (state_q)
`ifdef ALU_EXEC_MUL_EN
      MUL: begin
        prod_d = prod_next;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d    = DONE;
          done_d     = 1'b1;
          wb_write_d = 1'b1;
          wb_addr_d  = dest_q;
          wb_data_d  = prod_next[W-1:0];
          illegal_d  = 1'b0;
          flags_d    = {prod_next[W-1], (prod_next[W-1:0] == '0),
                        (prod_next[2*W-1:W] != '0), 1'b0};
        end
      end
`endif
      default: begin
        if (bus.start) begin
`ifdef ALU_EXEC_MUL_EN
          if (bus.opcode == OP_MUL) begin
            state_d = MUL;
            mcand_d = bus.op_a;
            prod_d  = {{W{1'b0}}, bus.op_b};
            cnt_d   = 4'd0;
            dest_d  = bus.dest;
          end else begin
`else
          begin
`endif
            state_d    = DONE;
            done_d     = 1'b1;
            wb_write_d = ~res.illegal;
            wb_addr_d  = bus.dest;
            wb_data_d  = res.data;
            flags_d    = res.flags;
            illegal_d  = res.illegal;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

`ifdef ALU_EXEC_MUL_EN
  assign bus.busy = (state_q == MUL);
`else
  assign bus.busy = 1'b0;
`endif
  assign bus.done     = done_q;
  assign bus.wb_write = wb_write_q;
  assign bus.wb_addr  = wb_addr_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.flags    = flags_q;
  assign bus.illegal  = illegal_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed testbench for alu_exec; covers both ALU_EXEC_MUL_EN builds.
module tb_alu_exec;

  logic clk = 1'b0;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  alu_exec_if #(.WORD_SIZE(16)) bus();

  alu_exec #(.WORD_SIZE(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // op, a, b, expected data, expected flags {N,Z,C,V}
  localparam int NV = 8;
  localparam logic [3:0]  V_OP [NV] = '{4'd7, 4'd8, 4'd5, 4'd6, 4'd3, 4'd4, 4'd0, 4'd1};
  localparam logic [15:0] V_A  [NV] = '{16'h8004, 16'h0000, 16'h0001, 16'h4001,
                                        16'h00F0, 16'hFFFF, 16'hFFFF, 16'h8000};
  localparam logic [15:0] V_B  [NV] = '{16'h0000, 16'h12AB, 16'h0000, 16'h0000,
                                        16'h0F00, 16'h0000, 16'h0001, 16'h0001};
  localparam logic [15:0] V_R  [NV] = '{16'hC002, 16'hAB00, 16'hFFFF, 16'h8002,
                                        16'h0FF0, 16'h0000, 16'h0000, 16'h7FFF};
  localparam logic [3:0]  V_F  [NV] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000,
                                        4'b0000, 4'b0100, 4'b0110, 4'b0011};

  task automatic drive(input logic s, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [1:0] d);
    bus.start  = s;
    bus.opcode = op;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.dest   = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b0, 4'd0, 16'h0, 16'h0, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({bus.busy, bus.done, bus.wb_write, bus.illegal, bus.wb_addr, bus.wb_data, bus.flags} !== 25'd0) begin
      fails++;
      $display("FAIL reset_outputs got busy=%b done=%b wr=%b ill=%b addr=%0d data=%h flags=%b want all zero",
               bus.busy, bus.done, bus.wb_write, bus.illegal, bus.wb_addr, bus.wb_data, bus.flags);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    tests++;
    if (bus.done !== 1'b0) begin
      fails++;
      $display("FAIL idle_done got %b want 0", bus.done);
    end
  endtask

  task automatic test_add();
    drive(1'b1, 4'd0, 16'h7FFF, 16'h0001, 2'd2);
    step();
    drive(1'b0, 4'd0, 16'h0, 16'h0, 2'd0);
    tests++;
    if ({bus.done, bus.wb_write, bus.illegal, bus.wb_addr} !== {1'b1, 1'b1, 1'b0, 2'd2}) begin
      fails++;
      $display("FAIL add_ctrl got done=%b wr=%b ill=%b addr=%0d want 1 1 0 2",
               bus.done, bus.wb_write, bus.illegal, bus.wb_addr);
    end
    tests++;
    if ({bus.wb_data, bus.flags} !== {16'h8000, 4'b1001}) begin
      fails++;
      $display("FAIL add_result got data=%h flags=%b want 8000 1001", bus.wb_data, bus.flags);
    end
    step();
    tests++;
    if ({bus.done, bus.wb_write, bus.wb_data, bus.wb_addr} !== {1'b0, 1'b0, 16'h8000, 2'd2}) begin
      fails++;
      $display("FAIL add_hold got done=%b wr=%b data=%h addr=%0d want 0 0 8000 2",
               bus.done, bus.wb_write, bus.wb_data, bus.wb_addr);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 4'd1, 16'd5, 16'd5, 2'd1);
    step();
    tests++;
    if ({bus.done, bus.wb_write, bus.wb_data, bus.flags} !== {1'b1, 1'b1, 16'h0000, 4'b0110}) begin
      fails++;
      $display("FAIL sub_equal got done=%b wr=%b data=%h flags=%b want 1 1 0000 0110",
               bus.done, bus.wb_write, bus.wb_data, bus.flags);
    end
    drive(1'b1, 4'd1, 16'd3, 16'd5, 2'd3);
    step();
    drive(1'b0, 4'd0, 16'h0, 16'h0, 2'd0);
    tests++;
    if ({bus.done, bus.wb_write, bus.wb_addr, bus.wb_data, bus.flags} !== {1'b1, 1'b1, 2'd3, 16'hFFFE, 4'b1000}) begin
      fails++;
      $display("FAIL sub_borrow got done=%b wr=%b addr=%0d data=%h flags=%b want 1 1 3 fffe 1000",
               bus.done, bus.wb_write, bus.wb_addr, bus.wb_data, bus.flags);
    end
    step();
    tests++;
    if (bus.done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_end got done=%b want 0", bus.done);
    end
  endtask

  task automatic test_ops();
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, V_OP[i], V_A[i], V_B[i], i[1:0]);
      step();
      tests++;
      if ({bus.done, bus.wb_write, bus.illegal, bus.wb_addr, bus.wb_data, bus.flags} !==
          {1'b1, 1'b1, 1'b0, i[1:0], V_R[i], V_F[i]}) begin
        fails++;
        $display("FAIL op%0d_vec%0d got done=%b wr=%b ill=%b addr=%0d data=%h flags=%b want 1 1 0 %0d %h %b",
                 V_OP[i], i, bus.done, bus.wb_write, bus.illegal, bus.wb_addr, bus.wb_data, bus.flags,
                 i[1:0], V_R[i], V_F[i]);
      end
    end
    drive(1'b0, 4'd0, 16'h0, 16'h0, 2'd0);
    step();
  endtask

`ifdef ALU_EXEC_MUL_EN
  task automatic test_mul();
    int bad;
    bad = 0;
    drive(1'b1, 4'd9, 16'd300, 16'd300, 2'd1);
    step();
    tests++;
    if ({bus.busy, bus.done, bus.wb_write} !== 3'b100) begin
      fails++;
      $display("FAIL mul_start got busy=%b done=%b wr=%b want 1 0 0", bus.busy, bus.done, bus.wb_write);
    end
    for (int i = 1; i <= 15; i++) begin
      drive(i[0], 4'd0, 16'hFFFF, 16'hFFFF, 2'd3);
      step();
      if ({bus.busy, bus.done, bus.wb_write} !== 3'b100) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL mul_busy got %0d bad cycles want 0", bad);
    end
    step();
    drive(1'b0, 4'd0, 16'h0, 16'h0, 2'd0);
    tests++;
    if ({bus.busy, bus.done, bus.wb_write, bus.wb_addr, bus.wb_data, bus.flags} !==
        {1'b0, 1'b1, 1'b1, 2'd1, 16'h5F90, 4'b0010}) begin
      fails++;
      $display("FAIL mul_result got busy=%b done=%b wr=%b addr=%0d data=%h flags=%b want 0 1 1 1 5f90 0010",
               bus.busy, bus.done, bus.wb_write, bus.wb_addr, bus.wb_data, bus.flags);
    end
    step();
    tests++;
    if ({bus.busy, bus.done, bus.wb_data} !== {1'b0, 1'b0, 16'h5F90}) begin
      fails++;
      $display("FAIL mul_noqueue got busy=%b done=%b data=%h want 0 0 5f90", bus.busy, bus.done, bus.wb_data);
    end
  endtask

  task automatic test_reset_abort();
    int wr;
    wr = 0;
    drive(1'b1, 4'd9, 16'd7, 16'd9, 2'd3);
    step();
    drive(1'b0, 4'd0, 16'h0, 16'h0, 2'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.wb_write !== 1'b0) wr++;
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if ({bus.busy, bus.done, bus.wb_write, bus.illegal, bus.wb_addr, bus.wb_data, bus.flags} !== 25'd0) begin
      fails++;
      $display("FAIL abort_clear got busy=%b done=%b wr=%b addr=%0d data=%h flags=%b want all zero",
               bus.busy, bus.done, bus.wb_write, bus.wb_addr, bus.wb_data, bus.flags);
    end
    repeat (2) step();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.wb_write !== 1'b0 || bus.busy !== 1'b0) wr++;
    end
    tests++;
    if (wr != 0) begin
      fails++;
      $display("FAIL abort_nowrite got %0d write/busy cycles want 0", wr);
    end
    test_and_after_reset();
  endtask
`else
  task automatic test_op9_illegal();
    drive(1'b1, 4'd9, 16'd300, 16'd300, 2'd1);
    step();
    drive(1'b0, 4'd0, 16'h0, 16'h0, 2'd0);
    tests++;
    if ({bus.busy, bus.done, bus.wb_write, bus.illegal, bus.wb_data, bus.flags} !==
        {1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 4'b0100}) begin
      fails++;
      $display("FAIL op9_illegal got busy=%b done=%b wr=%b ill=%b data=%h flags=%b want 0 1 0 1 0000 0100",
               bus.busy, bus.done, bus.wb_write, bus.illegal, bus.wb_data, bus.flags);
    end
    step();
  endtask

  task automatic test_reset_abort();
    drive(1'b1, 4'd0, 16'h1234, 16'h1111, 2'd3);
    step();
    drive(1'b0, 4'd0, 16'h0, 16'h0, 2'd0);
    reset_n = 1'b0;
    #1;
    tests++;
    if ({bus.busy, bus.done, bus.wb_write, bus.illegal, bus.wb_addr, bus.wb_data, bus.flags} !== 25'd0) begin
      fails++;
      $display("FAIL abort_clear got done=%b wr=%b addr=%0d data=%h flags=%b want all zero",
               bus.done, bus.wb_write, bus.wb_addr, bus.wb_data, bus.flags);
    end
    repeat (2) step();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    test_and_after_reset();
  endtask
`endif

  task automatic test_and_after_reset();
    drive(1'b1, 4'd2, 16'hF0F0, 16'h0FF0, 2'd0);
    step();
    drive(1'b0, 4'd0, 16'h0, 16'h0, 2'd0);
    tests++;
    if ({bus.done, bus.wb_write, bus.wb_data, bus.flags} !== {1'b1, 1'b1, 16'h00F0, 4'b0000}) begin
      fails++;
      $display("FAIL and_post_reset got done=%b wr=%b data=%h flags=%b want 1 1 00f0 0000",
               bus.done, bus.wb_write, bus.wb_data, bus.flags);
    end
    step();
  endtask

  task automatic test_illegal();
    drive(1'b1, 4'd12, 16'h5555, 16'hAAAA, 2'd2);
    step();
    drive(1'b0, 4'd0, 16'h0, 16'h0, 2'd0);
    tests++;
    if ({bus.done, bus.wb_write, bus.illegal, bus.wb_data, bus.flags} !==
        {1'b1, 1'b0, 1'b1, 16'h0000, 4'b0100}) begin
      fails++;
      $display("FAIL op12_illegal got done=%b wr=%b ill=%b data=%h flags=%b want 1 0 1 0000 0100",
               bus.done, bus.wb_write, bus.illegal, bus.wb_data, bus.flags);
    end
    step();
    drive(1'b1, 4'd3, 16'h0001, 16'h0002, 2'd1);
    step();
    drive(1'b0, 4'd0, 16'h0, 16'h0, 2'd0);
    tests++;
    if ({bus.done, bus.wb_write, bus.illegal, bus.wb_data} !== {1'b1, 1'b1, 1'b0, 16'h0003}) begin
      fails++;
      $display("FAIL illegal_clear got done=%b wr=%b ill=%b data=%h want 1 1 0 0003",
               bus.done, bus.wb_write, bus.illegal, bus.wb_data);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_ops();
`ifdef ALU_EXEC_MUL_EN
    test_mul();
`else
    test_op9_illegal();
`endif
    test_reset_abort();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
